// File: rtl/config_frame_loader.sv
// config_frame_loader: assembles 32-bit config words into frames and drives latch data/strobes
// Ports: CLK/resetn (sync, active-low); s_data/s_valid/s_ready word stream in;
// frame_data latch D bus; frame_strobe one-hot latch enables; col_sel column select;
// frame_done commit pulse; err sticky error; frame_count saturating commit count.
// Optional trailer-parity check is enabled by defining CONFIG_FRAME_PARITY_EN.
module config_frame_loader #(
  parameter int FRAME_WORDS = 4,
  parameter int NUM_FRAMES  = 20,
  parameter int NUM_COLS    = 16,
  parameter int STROBE_LEN  = 2,
  parameter int HOLD_LEN    = 1
) (
  input  logic                        CLK,
  input  logic                        resetn,
  input  logic [31:0]                 s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [32*FRAME_WORDS-1:0]   frame_data,
  output logic [NUM_FRAMES-1:0]       frame_strobe,
  output logic [$clog2(NUM_COLS)-1:0] col_sel,
  output logic                        frame_done,
  output logic                        err,
  output logic [15:0]                 frame_count
);
  localparam int DW  = 32*FRAME_WORDS;
  localparam int CSW = $clog2(NUM_COLS);
  localparam int FIW = $clog2(NUM_FRAMES);
  localparam int WW  = $clog2(FRAME_WORDS+1);
  localparam int CW  = $clog2((STROBE_LEN > HOLD_LEN ? STROBE_LEN : HOLD_LEN) + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD} state_t;
  state_t          state;
  logic [DW-1:0]   buf_q;
  logic [DW-1:0]   shifted;
  logic [WW-1:0]   wcnt;
  logic [CW-1:0]   cnt;
  logic [CSW-1:0]  col;
  logic [FIW-1:0]  fidx;
  logic            xfer;
  logic            hdr_ok;
  logic            bump;
`ifdef CONFIG_FRAME_PARITY_EN
  logic [31:0]     par;
`endif
  assign s_ready = resetn && (state == IDLE || state == LOAD);
  assign xfer    = s_valid && s_ready;
  // newest word enters at the bottom so the first word ends up most significant
  assign shifted = DW'({buf_q, s_data});
  assign hdr_ok  = s_data[31:24] == 8'hFA && 32'(s_data[23:16]) < NUM_COLS &&
                   32'(s_data[7:0]) < NUM_FRAMES;
  // asserted on the edge that enters the last HOLD cycle
  assign bump    = (state == STROBE && cnt == CW'(STROBE_LEN-1) && HOLD_LEN == 1) ||
                   (state == HOLD && HOLD_LEN > 1 && cnt == CW'(HOLD_LEN-2));
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state        <= IDLE;
      buf_q        <= '0;
      wcnt         <= '0;
      cnt          <= '0;
      col          <= '0;
      fidx         <= '0;
      frame_data   <= '0;
      frame_strobe <= '0;
      col_sel      <= '0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
      frame_count  <= '0;
`ifdef CONFIG_FRAME_PARITY_EN
      par          <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (xfer) begin
          if (hdr_ok) begin
            col   <= CSW'(s_data[23:16]);
            fidx  <= FIW'(s_data[7:0]);
            wcnt  <= '0;
`ifdef CONFIG_FRAME_PARITY_EN
            par   <= '0;
`endif
            state <= LOAD;
          end else err <= 1'b1;
        end
        LOAD: if (xfer) begin
`ifdef CONFIG_FRAME_PARITY_EN
          if (wcnt == WW'(FRAME_WORDS)) begin
            if (s_data == par) begin
              frame_data <= buf_q;
              col_sel    <= col;
              state      <= SETUP;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            buf_q <= shifted;
            par   <= par ^ s_data;
            wcnt  <= wcnt + 1'b1;
          end
`else
          buf_q <= shifted;
          wcnt  <= wcnt + 1'b1;
          if (wcnt == WW'(FRAME_WORDS-1)) begin
            frame_data <= shifted;
            col_sel    <= col;
            state      <= SETUP;
          end
`endif
        end
        SETUP: begin
          frame_strobe <= NUM_FRAMES'(1) << fidx;
          cnt          <= '0;
          state        <= STROBE;
        end
        STROBE: if (cnt == CW'(STROBE_LEN-1)) begin
          frame_strobe <= '0;
          cnt          <= '0;
          state        <= HOLD;
        end else cnt <= cnt + 1'b1;
        HOLD: if (cnt == CW'(HOLD_LEN-1)) begin
          col_sel <= '0;
          state   <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
      frame_done <= bump;
      if (bump && frame_count != 16'hFFFF) frame_count <= frame_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_config_frame_loader.sv
// tb_config_frame_loader: directed stimulus with a schedule-based reference model for config_frame_loader
module tb_config_frame_loader;
  localparam int FW = 4, NF = 20, NC = 16, SL = 2, HL = 1;
`ifdef CONFIG_FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  logic         CLK = 0;
  logic         resetn = 0;
  logic [31:0]  s_data = 0;
  logic         s_valid = 0;
  logic         s_ready;
  logic [127:0] frame_data;
  logic [19:0]  frame_strobe;
  logic [3:0]   col_sel;
  logic         frame_done;
  logic         err;
  logic [15:0]  frame_count;
  int n_chk = 0, n_fail = 0;
  logic [31:0] d [4];

  config_frame_loader dut (
    .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .frame_data(frame_data), .frame_strobe(frame_strobe), .col_sel(col_sel),
    .frame_done(frame_done), .err(err), .frame_count(frame_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: ph counts cycles since a commit (0 = accepting words).
  // ph=1 setup, ph=2..1+SL strobe, ph=2+SL..1+SL+HL hold; done on the final one.
  int          ph = 0;
  bit          hdr = 0, armed = 0, m_err = 0;
  int          m_col = 0, m_idx = 0, m_cnt = 0;
  logic [127:0] m_fd = 0;
  logic [31:0] q [$];

  always @(posedge CLK) begin
    logic [31:0] x;
    if (!resetn) begin
      ph = 0; hdr = 0; q.delete(); m_err = 0; m_cnt = 0; m_fd = 0; m_col = 0; armed = 1;
    end else if (ph != 0) begin
      ph = (ph == 1 + SL + HL) ? 0 : ph + 1;
      if (ph == 1 + SL + HL && m_cnt < 65535) m_cnt++;
    end else if (s_valid) begin
      if (!hdr) begin
        if (s_data[31:24] == 8'hFA && s_data[23:16] < NC && s_data[7:0] < NF) begin
          hdr = 1; m_col = s_data[23:16]; m_idx = s_data[7:0]; q.delete();
        end else m_err = 1;
      end else begin
        q.push_back(s_data);
        if (q.size() == FW + PAR) begin
          x = 0;
          for (int i = 0; i < FW; i++) x ^= q[i];
          if (PAR == 1 && q[q.size()-1] != x) m_err = 1;
          else begin
            m_fd = 0;
            for (int i = 0; i < FW; i++) m_fd = (m_fd << 32) | 128'(q[i]);
            ph = 1;
          end
          hdr = 0;
        end
      end
    end
  end

  always @(negedge CLK) if (armed) begin
    chk("s_ready", 128'(s_ready), 128'(resetn && ph == 0));
    chk("frame_data", frame_data, m_fd);
    chk("frame_strobe", 128'(frame_strobe), (ph >= 2 && ph <= 1 + SL) ? (128'(1) << m_idx) : 128'(0));
    chk("col_sel", 128'(col_sel), ph != 0 ? 128'(m_col) : 128'(0));
    chk("frame_done", 128'(frame_done), 128'(ph == 1 + SL + HL));
    chk("err", 128'(err), 128'(m_err));
    chk("frame_count", 128'(frame_count), 128'(m_cnt));
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send(input logic [31:0] w, output int waits);
    logic rdy;
    int n = 0;
    s_data = w; s_valid = 1;
    do begin
      @(negedge CLK); rdy = s_ready; @(posedge CLK); #1; n++;
    end while (!rdy && n < 50);
    waits = n - 1;
    if (!rdy) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout word %h: s_ready stayed %b, required 1", w, rdy);
    end
  endtask

  task automatic do_frame(input logic [31:0] h, input bit gaps, input bit bad_tr, output int waits);
    int w;
    logic [31:0] x = 0;
    send(h, waits);
    for (int i = 0; i < FW; i++) begin
      if (gaps) begin s_valid = 0; s_data = $urandom; step(1); end
      send(d[i], w);
      x ^= d[i];
    end
`ifdef CONFIG_FRAME_PARITY_EN
    send(bad_tr ? 32'h0 : x, w);
`else
    if (bad_tr) $display("note: trailer %h not sent without parity", x);
`endif
  endtask

  initial begin
    int w;
    d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    step(3);
    chk("rst_ready_low", 128'(s_ready), 0);
    chk("rst_strobe", 128'(frame_strobe), 0);
    chk("rst_data", frame_data, 0);
    chk("rst_count", 128'(frame_count), 0);
    resetn = 1; #1;
    chk("ready_after_rst", 128'(s_ready), 1);
    // first valid frame with literal expectations
    do_frame(32'hFA03_0005, 0, 0, w); s_valid = 0;
    chk("lit_data", frame_data, 128'h11111111_22222222_33333333_44444444);
    chk("lit_setup_strobe", 128'(frame_strobe), 0);
    step(1);
    chk("lit_strobe1", 128'(frame_strobe), 128'h00020);
    chk("lit_col", 128'(col_sel), 3);
    step(1);
    chk("lit_strobe2", 128'(frame_strobe), 128'h00020);
    step(1);
    chk("lit_done", 128'(frame_done), 1);
    chk("lit_count1", 128'(frame_count), 1);
    step(1);
    chk("lit_col_clear", 128'(col_sel), 0);
    // bad magic and bad frame index, then a good frame
    send(32'hAB00_0000, w);
    send(32'hFA00_0014, w); s_valid = 0;
    chk("lit_err", 128'(err), 1);
    chk("lit_idle_ready", 128'(s_ready), 1);
    d = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    do_frame(32'hFA01_0002, 0, 0, w); s_valid = 0;
    step(5);
    chk("lit_count2", 128'(frame_count), 2);
    // back-to-back frames, indices 0 then 19
    do_frame(32'hFA07_0000, 0, 0, w);
    do_frame(32'hFA0F_0013, 0, 0, w); s_valid = 0;
    chk("lit_b2b_gap", 128'(w), 4);
    step(5);
    chk("lit_count4", 128'(frame_count), 4);
    // valid toggling inside LOAD
    d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_frame(32'hFA02_0001, 1, 0, w); s_valid = 0;
    chk("lit_gap_data", frame_data, 128'h11111111_22222222_33333333_44444444);
    step(5);
    // reset during STROBE
    do_frame(32'hFA04_000A, 0, 0, w); s_valid = 0;
    step(1);
    chk("lit_strobe10", 128'(frame_strobe), 128'h00400);
    resetn = 0;
    step(1);
    chk("lit_rst_strobe", 128'(frame_strobe), 0);
    chk("lit_rst_count", 128'(frame_count), 0);
    resetn = 1;
    do_frame(32'hFA05_0003, 0, 0, w); s_valid = 0;
    step(4);
    chk("lit_count_after_rst", 128'(frame_count), 1);
`ifdef CONFIG_FRAME_PARITY_EN
    resetn = 0; step(2); resetn = 1;
    do_frame(32'hFA03_0005, 0, 0, w); s_valid = 0;
    step(1);
    chk("lit_par_strobe", 128'(frame_strobe), 128'h00020);
    step(3);
    d = '{32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    do_frame(32'hFA03_0006, 0, 1, w); s_valid = 0;
    chk("lit_par_err", 128'(err), 1);
    step(4);
    chk("lit_par_keep", frame_data, 128'h11111111_22222222_33333333_44444444);
    chk("lit_par_count", 128'(frame_count), 1);
`endif
    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
